// File: rtl/tlut_job_sequencer.sv
// Job sequencer for one simd_cell temporal-LUT multiply array.
// Streams operand pairs through fixed cell windows and returns the accumulators.
module tlut_job_sequencer #(
  parameter int DIM_A        = 9,
  parameter int DIM_C        = 9,
  parameter int INPUT_WIDTH  = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 13,
  parameter int WINDOW       = 16,
  parameter int DRAIN_CYCLES = 2,
  parameter int PAIR_CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic                          op_last,
  input  logic [DIM_A*INPUT_WIDTH-1:0]  op_input,
  input  logic [DIM_C*WEIGHT_WIDTH-1:0] op_weight,
  output logic                          cell_clear,
  output logic                          cell_enable,
  output logic [DIM_A*INPUT_WIDTH-1:0]  cell_input_bin,
  output logic [DIM_C*WEIGHT_WIDTH-1:0] cell_weight_bin,
  input  logic [DIM_A*ACC_WIDTH-1:0]    cell_product,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DIM_A*ACC_WIDTH-1:0]    res_data,
  output logic [PAIR_CNT_W-1:0]         res_pairs,
  output logic                          res_sat_risk,
  output logic                          busy
);

  localparam int WCNT_W  = $clog2(WINDOW);
  localparam int DCNT_W  = $clog2(DRAIN_CYCLES + 1);
  localparam int SAT_EXP =
    ACC_WIDTH - INPUT_WIDTH - WEIGHT_WIDTH;
  localparam int SAT_LIM = 1 << SAT_EXP;

  localparam logic [WCNT_W-1:0] W_LAST =
    WCNT_W'(WINDOW - 1);
  localparam logic [WCNT_W-1:0] W_PEN =
    WCNT_W'(WINDOW - 2);
  localparam logic [DCNT_W-1:0] D_LAST =
    DCNT_W'(DRAIN_CYCLES - 1);
  localparam logic [PAIR_CNT_W-1:0] SAT_P =
    PAIR_CNT_W'(SAT_LIM);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    OUT
  } state_t;

  state_t                  state;
  logic                    job_open;
  logic                    last_q;
  logic [PAIR_CNT_W-1:0]   pair_cnt;
  logic [PAIR_CNT_W-1:0]   pair_nxt;
  logic [WCNT_W-1:0]       wcnt;
  logic [DCNT_W-1:0]       dcnt;
  logic                    accept;

  assign accept = op_valid && op_ready;
  assign busy   = (state != IDLE);

  // A fresh job restarts the count; an open job saturates.
  always_comb begin
    pair_nxt = PAIR_CNT_W'(1);
    if (job_open) begin
      if (&pair_cnt) pair_nxt = pair_cnt;
      else pair_nxt = pair_cnt + PAIR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      job_open        <= 1'b0;
      last_q          <= 1'b0;
      pair_cnt        <= '0;
      wcnt            <= '0;
      dcnt            <= '0;
      op_ready        <= 1'b0;
      cell_clear      <= 1'b0;
      cell_enable     <= 1'b0;
      cell_input_bin  <= '0;
      cell_weight_bin <= '0;
      res_valid       <= 1'b0;
      res_data        <= '0;
      res_pairs       <= '0;
      res_sat_risk    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          op_ready <= 1'b1;
          if (accept) begin
            cell_input_bin  <= op_input;
            cell_weight_bin <= op_weight;
            last_q          <= op_last;
            pair_cnt        <= pair_nxt;
            op_ready        <= 1'b0;
            if (job_open) begin
              state       <= RUN;
              cell_enable <= 1'b1;
              wcnt        <= '0;
            end else begin
              state      <= CLEAR;
              cell_clear <= 1'b1;
            end
          end
        end

        CLEAR: begin
          cell_clear  <= 1'b0;
          job_open    <= 1'b1;
          cell_enable <= 1'b1;
          wcnt        <= '0;
          state       <= RUN;
        end

        RUN: begin
          wcnt <= wcnt + WCNT_W'(1);
          // Open the operand port only for the window's final cycle.
          if (wcnt == W_PEN) op_ready <= !last_q;
          if (wcnt == W_LAST) begin
            wcnt     <= '0;
            op_ready <= 1'b0;
            if (last_q) begin
              state       <= DRAIN;
              cell_enable <= 1'b0;
              dcnt        <= '0;
            end else if (accept) begin
              cell_input_bin  <= op_input;
              cell_weight_bin <= op_weight;
              last_q          <= op_last;
              pair_cnt        <= pair_nxt;
            end else begin
              state       <= IDLE;
              cell_enable <= 1'b0;
              op_ready    <= 1'b1;
            end
          end
        end

        DRAIN: begin
          dcnt <= dcnt + DCNT_W'(1);
          if (dcnt == D_LAST) begin
            res_data     <= cell_product;
            res_pairs    <= pair_cnt;
            res_sat_risk <= (pair_cnt > SAT_P);
            res_valid    <= 1'b1;
            state        <= OUT;
          end
        end

        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_open  <= 1'b0;
            op_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlut_job_sequencer.sv
// Scoreboard bench for tlut_job_sequencer with a behavioural
// temporal-LUT cell that adds one input*weight product per window.
module tb_tlut_job_sequencer;

  localparam int DA  = 9;
  localparam int DC  = 9;
  localparam int IW  = 4;
  localparam int WW  = 8;
  localparam int AW  = 13;
  localparam int WIN = 16;
  localparam int DR  = 2;
  localparam int PW  = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                op_valid = 1'b0;
  logic                op_ready;
  logic                op_last = 1'b0;
  logic [DA*IW-1:0]    op_input = '0;
  logic [DC*WW-1:0]    op_weight = '0;
  logic                cell_clear;
  logic                cell_enable;
  logic [DA*IW-1:0]    cell_input_bin;
  logic [DC*WW-1:0]    cell_weight_bin;
  logic [DA*AW-1:0]    cell_product;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic [DA*AW-1:0]    res_data;
  logic [PW-1:0]       res_pairs;
  logic                res_sat_risk;
  logic                busy;

  tlut_job_sequencer #(
    .DIM_A(DA), .DIM_C(DC), .INPUT_WIDTH(IW),
    .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW), .WINDOW(WIN),
    .DRAIN_CYCLES(DR), .PAIR_CNT_W(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_last(op_last), .op_input(op_input),
    .op_weight(op_weight),
    .cell_clear(cell_clear), .cell_enable(cell_enable),
    .cell_input_bin(cell_input_bin),
    .cell_weight_bin(cell_weight_bin),
    .cell_product(cell_product),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_pairs(res_pairs),
    .res_sat_risk(res_sat_risk), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural cell: product lands once per completed window.
  logic [AW-1:0] acc [DA];
  int ph = 0;
  initial for (int i = 0; i < DA; i++) acc[i] = '0;

  always @(posedge clk) begin
    if (cell_clear) begin
      for (int i = 0; i < DA; i++) acc[i] <= '0;
      ph <= 0;
    end else if (cell_enable) begin
      if (ph == WIN - 1) begin
        for (int i = 0; i < DA; i++) begin
          int p;
          p = int'(cell_input_bin[i*IW +: IW]) *
              int'(cell_weight_bin[i*WW +: WW]);
          acc[i] <= acc[i] + AW'(p);
        end
        ph <= 0;
      end else begin
        ph <= ph + 1;
      end
    end
  end

  always_comb begin
    cell_product = '0;
    for (int i = 0; i < DA; i++)
      cell_product[i*AW +: AW] = acc[i];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [127:0] act,
                     logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic [DA*AW-1:0] data;
    logic [PW-1:0]    pairs;
    logic             risk;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 128'(1), 128'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_data", 128'(res_data), 128'(e.data));
        chk("res_pairs", 128'(res_pairs), 128'(e.pairs));
        chk("res_sat_risk", 128'(res_sat_risk),
            128'(e.risk));
      end
    end
  end

  int n_clear, n_en, en_first, en_last, clr_cyc;

  always @(negedge clk) begin
    if (cell_clear) begin
      n_clear++;
      clr_cyc = cyc;
    end
    if (cell_enable) begin
      n_en++;
      if (en_first < 0) en_first = cyc;
      en_last = cyc;
    end
  end

  task automatic clr_stats();
    n_clear = 0; n_en = 0;
    en_first = -1; en_last = -1; clr_cyc = -1;
  endtask

  // Reference job model: plain sums of lane products.
  int jacc[DA];
  int jpairs;
  int t_acc;

  task automatic job_start();
    for (int i = 0; i < DA; i++) jacc[i] = 0;
    jpairs = 0;
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [DA*IW-1:0] rnd_in();
    logic [DA*IW-1:0] r;
    for (int i = 0; i < DA; i++)
      r[i*IW +: IW] = IW'($urandom_range(0, 15));
    return r;
  endfunction

  function automatic logic [DC*WW-1:0] rnd_w();
    logic [DC*WW-1:0] r;
    for (int i = 0; i < DC; i++)
      r[i*WW +: WW] = WW'($urandom_range(0, 255));
    return r;
  endfunction

  task automatic send_pair(logic [DA*IW-1:0] in,
                           logic [DC*WW-1:0] w, bit last);
    bit ok;
    for (int i = 0; i < DA; i++)
      jacc[i] += int'(in[i*IW +: IW]) * int'(w[i*WW +: WW]);
    jpairs++;
    if (last) begin
      exp_t e;
      for (int i = 0; i < DA; i++)
        e.data[i*AW +: AW] = AW'(jacc[i] % (1 << AW));
      e.pairs = (jpairs > 255) ? 8'hFF : PW'(jpairs);
      e.risk  = (jpairs > 2);
      sb.push_back(e);
    end
    op_input  = in;
    op_weight = w;
    op_last   = last;
    op_valid  = 1'b1;
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (op_ready) ok = 1;
    end
    if (!ok) begin
      chk("accept_timeout", 128'(0), 128'(1));
      op_valid = 1'b0;
      return;
    end
    t_acc = cyc;
    @(posedge clk);
    #2;
    op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) ok = 1;
    end
    if (!ok) chk("idle_timeout", 128'(0), 128'(1));
    tick(1);
  endtask

  task automatic wait_res(output int t);
    t = -1;
    for (int n = 0; n < 100 && t < 0; n++) begin
      @(negedge clk);
      if (res_valid) t = cyc;
    end
    if (t < 0) chk("res_timeout", 128'(0), 128'(1));
  endtask

  bit rr_rand = 0;
  always @(posedge clk) begin
    if (rr_rand) begin
      #2;
      res_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DA*IW-1:0] in_b;
    logic [DC*WW-1:0] w_b;
    logic [DA*AW-1:0] held;
    int t0, tr, np;
    bit ok;

    clr_stats();
    rst_n = 1'b0;
    op_valid = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_op_ready", 128'(op_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_cell_ctl", 128'({cell_clear, cell_enable}),
        128'(0));
    chk("rst_cell_bins",
        128'({cell_input_bin, cell_weight_bin}), 128'(0));
    chk("rst_res", 128'({res_valid, res_pairs,
        res_sat_risk}), 128'(0));
    chk("rst_res_data", 128'(res_data), 128'(0));
    tick(1);
    rst_n = 1'b1;
    op_valid = 1'b0;
    @(negedge clk);
    chk("op_ready_pre_release", 128'(op_ready), 128'(0));
    tick(1);
    @(negedge clk);
    chk("op_ready_post_release", 128'(op_ready), 128'(1));
    tick(1);

    // Single-pair job with lanes {8,9,10}.
    res_ready = 1'b1;
    in_b = '0;
    w_b  = '0;
    in_b[0 +: IW] = 4'd8;
    in_b[IW +: IW] = 4'd9;
    in_b[2*IW +: IW] = 4'd10;
    w_b[0 +: WW] = 8'd8;
    w_b[WW +: WW] = 8'd9;
    w_b[2*WW +: WW] = 8'd10;
    clr_stats();
    job_start();
    send_pair(in_b, w_b, 1'b1);
    t0 = t_acc;
    wait_res(tr);
    chk("res_latency", 128'(tr - t0), 128'(WIN + DR + 2));
    chk("res_data_directed", 128'(res_data[3*AW-1:0]),
        128'({13'd100, 13'd81, 13'd64}));
    wait_idle();
    chk("clear_cycle", 128'(clr_cyc - t0), 128'(1));
    chk("clear_count", 128'(n_clear), 128'(1));
    chk("en_first", 128'(en_first - t0), 128'(2));
    chk("en_last", 128'(en_last - t0), 128'(WIN + 1));
    chk("en_count", 128'(n_en), 128'(WIN));

    // Three back-to-back pairs.
    clr_stats();
    job_start();
    send_pair(rnd_in(), rnd_w(), 1'b0);
    send_pair(rnd_in(), rnd_w(), 1'b0);
    send_pair(rnd_in(), rnd_w(), 1'b1);
    wait_idle();
    chk("b2b_clear_count", 128'(n_clear), 128'(1));
    chk("b2b_en_count", 128'(n_en), 128'(3 * WIN));
    chk("b2b_en_span", 128'(en_last - en_first + 1),
        128'(3 * WIN));

    // Gap between pairs.
    clr_stats();
    job_start();
    send_pair(rnd_in(), rnd_w(), 1'b0);
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    chk("gap_reached_idle", 128'(ok), 128'(1));
    for (int n = 0; n < 5; n++) begin
      chk("gap_enable_low", 128'(cell_enable), 128'(0));
      @(negedge clk);
    end
    tick(1);
    send_pair(rnd_in(), rnd_w(), 1'b1);
    wait_idle();
    chk("gap_clear_count", 128'(n_clear), 128'(1));
    chk("gap_en_count", 128'(n_en), 128'(2 * WIN));
    chk("gap_present",
        128'((en_last - en_first + 1) > 2 * WIN), 128'(1));

    // Result backpressure.
    res_ready = 1'b0;
    job_start();
    send_pair(rnd_in(), rnd_w(), 1'b1);
    wait_res(tr);
    held = res_data;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_res_valid", 128'(res_valid), 128'(1));
      chk("bp_res_data", 128'(res_data), 128'(held));
      chk("bp_op_ready", 128'(op_ready), 128'(0));
    end
    tick(1);
    res_ready = 1'b1;
    wait_idle();
    clr_stats();
    job_start();
    send_pair(rnd_in(), rnd_w(), 1'b1);
    wait_idle();
    chk("post_bp_clear", 128'(n_clear), 128'(1));

    // Reset in the middle of the second window.
    clr_stats();
    job_start();
    send_pair(rnd_in(), rnd_w(), 1'b0);
    send_pair(rnd_in(), rnd_w(), 1'b1);
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (n_en == WIN + 8) ok = 1;
    end
    chk("mid_run_reached", 128'(ok), 128'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ctl", 128'({op_ready, cell_clear,
        cell_enable, busy, res_valid}), 128'(0));
    chk("midrst_bins", 128'({cell_input_bin,
        cell_weight_bin}), 128'(0));
    void'(sb.pop_back());
    tick(1);
    rst_n = 1'b1;
    tick(2);
    clr_stats();
    job_start();
    send_pair(rnd_in(), rnd_w(), 1'b1);
    wait_idle();
    chk("post_rst_clear", 128'(n_clear), 128'(1));
    chk("post_rst_en", 128'(n_en), 128'(WIN));

    // Random jobs with gaps and random result backpressure.
    rr_rand = 1;
    for (int j = 0; j < 15; j++) begin
      np = $urandom_range(1, 4);
      job_start();
      for (int p = 0; p < np; p++) begin
        send_pair(rnd_in(), rnd_w(), p == np - 1);
        if ($urandom_range(0, 2) == 0)
          tick($urandom_range(1, 3));
      end
    end
    rr_rand = 0;
    tick(1);
    res_ready = 1'b1;
    wait_idle();

    // Pair counter saturation.
    job_start();
    for (int p = 0; p < 260; p++)
      send_pair(rnd_in(), rnd_w(), p == 259);
    wait_idle();

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/tlut_job_sequencer.md
Name: tlut_job_sequencer

Overview:
- Sequences one simd_cell temporal-LUT multiply array through multiply-accumulate jobs.
- A job is one or more operand pairs (input vector, weight vector) accepted over a valid/ready stream. For each pair the block holds the operands on the cell and asserts cell enable for a fixed temporal window.
- After the last pair it waits for the cell pipeline to drain, captures the lane accumulators and presents the result on a valid/ready output.
- Sits between the operand buffer/DMA and the simd_cell instance.

Parameters:
- DIM_A, 9, number of input lanes / accumulator lanes.
- DIM_C, 9, number of weight lanes.
- INPUT_WIDTH, 4, bits per input element.
- WEIGHT_WIDTH, 8, bits per weight element.
- ACC_WIDTH, 13, bits per lane accumulator.
- WINDOW, 16, cell_enable cycles per operand pair (2**INPUT_WIDTH); must be >= 2.
- DRAIN_CYCLES, 2, idle cycles between the last window and result capture; must be >= 1.
- PAIR_CNT_W, 8, width of the pair counter.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: synchronous active-low reset.
- op_valid, in, 1: operand pair valid.
- op_ready, out, 1: operand pair accepted when op_valid && op_ready.
- op_last, in, 1: the pair is the last of the job.
- op_input, in, DIM_A*INPUT_WIDTH: input vector.
- op_weight, in, DIM_C*WEIGHT_WIDTH: weight vector.
- cell_clear, out, 1: one-cycle pulse that zeros the cell accumulators.
- cell_enable, out, 1: drives simd_cell enable.
- cell_input_bin, out, DIM_A*INPUT_WIDTH: registered input to the cell.
- cell_weight_bin, out, DIM_C*WEIGHT_WIDTH: registered weight to the cell.
- cell_product, in, DIM_A*ACC_WIDTH: simd_cell product_acc.
- res_valid, out, 1: result valid.
- res_ready, in, 1: result accepted when res_valid && res_ready.
- res_data, out, DIM_A*ACC_WIDTH: captured accumulators.
- res_pairs, out, PAIR_CNT_W: number of pairs in the job; saturates at all-ones.
- res_sat_risk, out, 1: set when the job has more than 2**(ACC_WIDTH-INPUT_WIDTH-WEIGHT_WIDTH) pairs (default 2).
- busy, out, 1: high in every state except IDLE.

Behaviour:
- Reset (rst_n low at a clock edge), from any state including mid-job:
  - state=IDLE; job_open=0; pair and window counters=0.
  - All outputs 0, including op_ready, cell_*, res_* and busy.
  - op_ready rises in the first cycle after rst_n is sampled high.
  - A job in progress is discarded. No cell_clear is issued on reset; the next job clears the cell itself.
- FSM states: IDLE, CLEAR, RUN, DRAIN, OUT.
- IDLE:
  - op_ready=1.
  - On accept: register op_input/op_weight into cell_input_bin/cell_weight_bin, latch op_last, and increment the pair counter (reset to 1 if job_open=0).
  - If job_open=0, go to CLEAR; otherwise go to RUN.
- CLEAR:
  - Exactly one cycle with cell_clear=1 and cell_enable=0; sets job_open=1.
  - Then go to RUN.
- RUN:
  - cell_enable=1 for exactly WINDOW consecutive cycles; the window counter runs 0..WINDOW-1.
  - cell_input_bin/cell_weight_bin are stable for the whole window.
  - op_ready=0, except in the final window cycle when the latched last=0.
  - Final cycle, latched last=1: go to DRAIN.
  - Final cycle, last=0, accept occurs: operands are registered and the next RUN window starts on the next cycle with no gap. CLEAR is not repeated.
  - Final cycle, last=0, no accept: go to IDLE with job_open=1. cell_enable=0 while waiting.
- DRAIN:
  - cell_enable=0 for DRAIN_CYCLES cycles.
  - On the last DRAIN cycle, capture cell_product into res_data and the pair count into res_pairs, and evaluate res_sat_risk.
  - Then go to OUT.
- OUT:
  - res_valid=1; res_data/res_pairs/res_sat_risk are held stable; op_ready=0.
  - On res_ready, go to IDLE with job_open=0. res_valid drops the following cycle.
  - res_ready is ignored outside OUT.
- Latency, single-pair job, no backpressure: accept at cycle 0 → CLEAR at 1 → RUN at 2..WINDOW+1 → DRAIN → res_valid at cycle WINDOW+DRAIN_CYCLES+2 (20 with defaults).
- The pair counter saturates at 2**PAIR_CNT_W-1 and does not wrap.
- res_sat_risk is advisory only; accumulator data is not altered.
- op_valid may drop without acceptance; no state change occurs.

Test Plan:
- Reset checks:
  - Hold rst_n=0 for 3 clocks with op_valid=1 → all outputs 0 and op_ready=0.
  - Release → op_ready=1 next cycle.
- Single-pair job, lanes {8,9,10}, weights {8,9,10}, op_last=1:
  - cell_clear pulses once at cycle 1 and cell_enable is high cycles 2..17.
  - res_valid at cycle 20 with res_data lanes {64,81,100} (bench cell model adds lane input*weight per window), res_pairs=1, res_sat_risk=0.
- Three-pair job with op_valid held high:
  - Windows are back-to-back (48 contiguous cell_enable cycles) with a single cell_clear.
  - res_pairs=3, res_sat_risk=1.
- Gap between pairs (op_valid low 5 cycles after the first window):
  - cell_enable=0 during the gap, no second cell_clear.
  - Result equals the sum of both pairs.
- Result backpressure: res_ready low for 10 cycles →
  - res_valid and res_data stay stable.
  - op_ready=0 throughout.
  - After the handshake, a new job issues a fresh cell_clear.
- Reset mid-RUN (cycle 8 of the window):
  - Outputs are 0 the next cycle.
  - The next job starts with CLEAR and returns only its own products.
